// File: rtl/reg_decode_issue.sv
// Decode/issue stage: latches one MIPS word, decodes it, checks the register window and scoreboard, then issues it.
// Latency: word accepted at edge N is evaluated at N+1 and issued (issueValid high) after N+1; one instruction every 3 cycles at best.
// Backpressure: instReady is low outside EMPTY; issue* holds stable until issueReady; RAW/WAW hazards stall in HOLD.
module reg_decode_issue #(
  parameter int REG_BASE  = 8,
  parameter int REG_COUNT = 16,
  parameter int STALL_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instValid,
  input  logic [31:0]        instData,
  output logic               instReady,
  output logic               issueValid,
  input  logic               issueReady,
  output logic [5:0]         issueOpcode,
  output logic [4:0]         issueRs,
  output logic [4:0]         issueRt,
  output logic [4:0]         issueDest,
  output logic               issueWrite,
  output logic [15:0]        issueImm,
  input  logic               wbValid,
  input  logic [4:0]         wbAddress,
  output logic               regError,
  output logic [STALL_W-1:0] stallCount
);

  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_OUT} state_t;

  state_t               state;
  logic [31:0]          inst_q;
  logic [REG_COUNT-1:0] busy;

  // True when an architectural address falls inside the tracked window.
  function automatic logic in_window(input logic [4:0] a);
    return (int'(a) >= REG_BASE) && (int'(a) <= REG_BASE + REG_COUNT - 1);
  endfunction

  // Scoreboard index of an in-window address.
  function automatic logic [IDX_W-1:0] win_idx(input logic [4:0] a);
    logic [4:0] d;
    d = a - 5'(REG_BASE);
    return d[IDX_W-1:0];
  endfunction

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       legal, use_rs, use_rt, writes;
  logic [4:0] dest;
  logic       out_of_window, hazard, bad;

  assign op = inst_q[31:26];
  assign rs = inst_q[25:21];
  assign rt = inst_q[20:16];
  assign rd = inst_q[15:11];

  // Classify the latched opcode into source usage and destination.
  always_comb begin
    legal  = 1'b1;
    use_rs = 1'b0;
    use_rt = 1'b0;
    writes = 1'b0;
    dest   = 5'd0;
    case (op)
      6'h00: begin use_rs = 1'b1; use_rt = 1'b1; writes = 1'b1; dest = rd; end
      6'h08,
      6'h23: begin use_rs = 1'b1; writes = 1'b1; dest = rt; end
      6'h2B,
      6'h04: begin use_rs = 1'b1; use_rt = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // Window and hazard checks only consider the fields this opcode actually uses.
  always_comb begin
    out_of_window = (use_rs && !in_window(rs)) ||
                    (use_rt && !in_window(rt)) ||
                    (writes && !in_window(dest));
    hazard = (use_rs && busy[win_idx(rs)]) ||
             (use_rt && busy[win_idx(rt)]) ||
             (writes && busy[win_idx(dest)]);
    bad = !legal || out_of_window;
  end

  assign instReady = (state == S_EMPTY);

  // Capture / evaluate / issue sequencing with registered issue outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_EMPTY;
      inst_q      <= '0;
      issueValid  <= 1'b0;
      issueOpcode <= '0;
      issueRs     <= '0;
      issueRt     <= '0;
      issueDest   <= '0;
      issueWrite  <= 1'b0;
      issueImm    <= '0;
      regError    <= 1'b0;
      stallCount  <= '0;
    end else begin
      regError <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (instValid) begin
            inst_q <= instData;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bad) begin
            regError <= 1'b1;
            state    <= S_EMPTY;
          end else if (hazard) begin
            if (stallCount != {STALL_W{1'b1}})
              stallCount <= stallCount + STALL_W'(1);
          end else begin
            issueValid  <= 1'b1;
            issueOpcode <= op;
            issueRs     <= rs;
            issueRt     <= rt;
            issueDest   <= dest;
            issueWrite  <= writes;
            issueImm    <= inst_q[15:0];
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (issueReady) begin
            issueValid <= 1'b0;
            state      <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Busy scoreboard: writeback clears, issue handshake sets; set wins on collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wbValid && in_window(wbAddress))
        busy[win_idx(wbAddress)] <= 1'b0;
      if (state == S_OUT && issueValid && issueReady && issueWrite)
        busy[win_idx(issueDest)] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_decode_issue.sv
// Bench for reg_decode_issue: directed scenarios with literal expectations, then randomized traffic.
// A behavioural model (busy set over architectural addresses, one pending slot) is compared every cycle.
// Inputs change 1 time unit after the falling edge; outputs are compared on the falling edge.
module tb_reg_decode_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instValid = 1'b0;
  logic [31:0] instData = '0;
  logic        instReady;
  logic        issueValid;
  logic        issueReady = 1'b1;
  logic [5:0]  issueOpcode;
  logic [4:0]  issueRs, issueRt, issueDest;
  logic        issueWrite;
  logic [15:0] issueImm;
  logic        wbValid = 1'b0;
  logic [4:0]  wbAddress = '0;
  logic        regError;
  logic [15:0] stallCount;

  int checks = 0;
  int failures = 0;

  reg_decode_issue #(.REG_BASE(8), .REG_COUNT(16), .STALL_W(16)) dut (
    .clk(clk), .reset(reset),
    .instValid(instValid), .instData(instData), .instReady(instReady),
    .issueValid(issueValid), .issueReady(issueReady),
    .issueOpcode(issueOpcode), .issueRs(issueRs), .issueRt(issueRt),
    .issueDest(issueDest), .issueWrite(issueWrite), .issueImm(issueImm),
    .wbValid(wbValid), .wbAddress(wbAddress),
    .regError(regError), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_held = 0, m_out = 0, m_err = 0;
  bit [31:0]   m_word = '0;
  bit          m_busy [32];
  int unsigned m_stall = 0;
  bit [5:0]    m_op = '0;
  bit [4:0]    m_rs = '0, m_rt = '0, m_dest = '0;
  bit          m_write = 0;
  bit [15:0]   m_imm = '0;

  function automatic bit in_win(input bit [4:0] a);
    return a >= 5'd8 && a <= 5'd23;
  endfunction

  function automatic void decode(input bit [31:0] w, output bit legal, output bit urs,
                                 output bit urt, output bit wr, output bit [4:0] dst);
    legal = 1; urs = 0; urt = 0; wr = 0; dst = 0;
    case (w[31:26])
      6'h00:        begin urs = 1; urt = 1; wr = 1; dst = w[15:11]; end
      6'h08, 6'h23: begin urs = 1; wr = 1; dst = w[20:16]; end
      6'h2B, 6'h04: begin urs = 1; urt = 1; end
      default:      legal = 0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit n_held, n_out, n_err, set_en, legal, urs, urt, wr, oow, haz;
    bit [4:0] dst, set_addr, a_rs, a_rt;
    bit n_busy [32];
    int unsigned n_stall;
    n_held = m_held; n_out = m_out; n_err = 0; n_stall = m_stall;
    n_busy = m_busy; set_en = 0; set_addr = 0;
    if (reset) begin
      n_held = 0; n_out = 0; n_stall = 0;
      foreach (n_busy[i]) n_busy[i] = 0;
    end else begin
      if (m_out) begin
        if (issueReady) begin
          set_en = m_write; set_addr = m_dest; n_out = 0;
        end
      end else if (m_held) begin
        decode(m_word, legal, urs, urt, wr, dst);
        a_rs = m_word[25:21]; a_rt = m_word[20:16];
        oow = (urs && !in_win(a_rs)) || (urt && !in_win(a_rt)) || (wr && !in_win(dst));
        haz = (urs && m_busy[a_rs]) || (urt && m_busy[a_rt]) || (wr && m_busy[dst]);
        if (!legal || oow) begin
          n_err = 1; n_held = 0;
        end else if (haz) begin
          if (n_stall < 65535) n_stall = n_stall + 1;
        end else begin
          n_held = 0; n_out = 1;
          m_op <= m_word[31:26]; m_rs <= a_rs; m_rt <= a_rt;
          m_dest <= wr ? dst : 5'd0; m_write <= wr; m_imm <= m_word[15:0];
        end
      end else if (instValid) begin
        m_word <= instData; n_held = 1;
      end
      if (wbValid && in_win(wbAddress)) n_busy[wbAddress] = 0;
      if (set_en) n_busy[set_addr] = 1;
    end
    m_held <= n_held; m_out <= n_out; m_err <= n_err; m_stall <= n_stall; m_busy <= n_busy;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("instReady", 32'(instReady), 32'(!m_held && !m_out));
    chk("issueValid", 32'(issueValid), 32'(m_out));
    chk("regError", 32'(regError), 32'(m_err));
    chk("stallCount", 32'(stallCount), m_stall);
    if (m_out) begin
      chk("issueOpcode", 32'(issueOpcode), 32'(m_op));
      chk("issueRs", 32'(issueRs), 32'(m_rs));
      chk("issueRt", 32'(issueRt), 32'(m_rt));
      chk("issueDest", 32'(issueDest), 32'(m_dest));
      chk("issueWrite", 32'(issueWrite), 32'(m_write));
      chk("issueImm", 32'(issueImm), 32'(m_imm));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    while (!instReady && n < 40) begin step(); n++; end
    if (!instReady) chk("send_wait_ready", 32'(instReady), 32'd1);
    instValid = 1'b1; instData = w;
    step();
    instValid = 1'b0;
  endtask

  task automatic writeback(input logic [4:0] a);
    wbValid = 1'b1; wbAddress = a;
    step();
    wbValid = 1'b0;
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 12) == 0) return 5'($urandom_range(0, 31));
    return 5'(8 + $urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] op;
    int k = $urandom_range(0, 9);
    case (k)
      4: op = 6'h08;
      5: op = 6'h23;
      6: op = 6'h2B;
      7: op = 6'h04;
      8: op = 6'($urandom_range(0, 63));
      default: op = 6'h00;
    endcase
    if (op == 6'h00) return {op, rand_reg(), rand_reg(), rand_reg(), 5'd0, 6'h20};
    return {op, rand_reg(), rand_reg(), 16'($urandom_range(0, 65535))};
  endfunction

  initial begin
    // Reset values
    repeat (3) step();
    chk("rst_instReady", 32'(instReady), 32'd1);
    chk("rst_issueValid", 32'(issueValid), 32'd0);
    chk("rst_issueDest", 32'(issueDest), 32'd0);
    chk("rst_stallCount", 32'(stallCount), 32'd0);
    chk("rst_regError", 32'(regError), 32'd0);
    reset = 1'b0;
    step();

    // add $8,$9,$10: issued two edges after capture
    issueReady = 1'b1;
    send(32'h012A4020);
    chk("add_capture_no_issue", 32'(issueValid), 32'd0);
    step();
    chk("add_latency", 32'(issueValid), 32'd1);
    chk("add_rs", 32'(issueRs), 32'd9);
    chk("add_rt", 32'(issueRt), 32'd10);
    chk("add_dest", 32'(issueDest), 32'd8);
    chk("add_write", 32'(issueWrite), 32'd1);
    step();

    // lw $9,0($8): $8 busy from the add -> stalls until writeback of $8
    send(32'h8D090000);
    repeat (3) step();
    chk("lw_stall3", 32'(stallCount), 32'd3);
    writeback(5'd8);
    chk("lw_stall_wb_cycle", 32'(stallCount), 32'd4);
    chk("lw_no_bypass", 32'(issueValid), 32'd0);
    step();
    chk("lw_issue", 32'(issueValid), 32'd1);
    chk("lw_dest", 32'(issueDest), 32'd9);
    chk("lw_rt", 32'(issueRt), 32'd9);
    chk("lw_rs", 32'(issueRs), 32'd8);
    step();

    // add $10,$9,$9: RAW on $9
    send(32'h01295020);
    repeat (2) step();
    chk("raw_stall", 32'(issueValid), 32'd0);
    writeback(5'd9);
    step();
    chk("raw_release", 32'(issueValid), 32'd1);
    chk("raw_dest", 32'(issueDest), 32'd10);
    step();

    // Illegal opcode, then out-of-window add $1,$2,$3
    send(32'hFC000000);
    step();
    chk("illegal_err", 32'(regError), 32'd1);
    chk("illegal_ready", 32'(instReady), 32'd1);
    chk("illegal_noissue", 32'(issueValid), 32'd0);
    step();
    chk("illegal_pulse_end", 32'(regError), 32'd0);
    send(32'h00430820);
    step();
    chk("oow_err", 32'(regError), 32'd1);
    chk("oow_noissue", 32'(issueValid), 32'd0);
    step();

    // add $11,$12,$13 under downstream backpressure
    issueReady = 1'b0;
    send(32'h018D5820);
    step();
    chk("bp_issue", 32'(issueValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instReady", 32'(instReady), 32'd0);
      chk("bp_dest_stable", 32'(issueDest), 32'd11);
      chk("bp_rs_stable", 32'(issueRs), 32'd12);
    end
    issueReady = 1'b1;
    step();
    chk("bp_released", 32'(issueValid), 32'd0);
    chk("bp_ready_back", 32'(instReady), 32'd1);

    // sw $9,4($8): no register write
    send(32'hAD090004);
    step();
    chk("sw_issue", 32'(issueValid), 32'd1);
    chk("sw_write", 32'(issueWrite), 32'd0);
    chk("sw_dest", 32'(issueDest), 32'd0);
    chk("sw_imm", 32'(issueImm), 32'd4);
    step();

    // beq $11,$12: $11 still busy
    send(32'h116C0003);
    repeat (2) step();
    chk("beq_stall", 32'(issueValid), 32'd0);
    writeback(5'd11);
    step();
    chk("beq_issue", 32'(issueValid), 32'd1);
    chk("beq_opcode", 32'(issueOpcode), 32'h04);
    step();

    // Reset while stalled in HOLD on busy $10
    send(32'h014A6020);
    repeat (2) step();
    chk("pre_reset_stall", 32'(issueValid), 32'd0);
    reset = 1'b1;
    #1;
    chk("arst_issueValid", 32'(issueValid), 32'd0);
    chk("arst_instReady", 32'(instReady), 32'd1);
    chk("arst_stallCount", 32'(stallCount), 32'd0);
    chk("arst_issueRs", 32'(issueRs), 32'd0);
    step();
    reset = 1'b0;
    send(32'h014A6020);
    step();
    chk("post_reset_no_stall", 32'(issueValid), 32'd1);
    chk("post_reset_stall0", 32'(stallCount), 32'd0);
    step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 599) == 0);
      instValid  = $urandom_range(0, 1) == 1;
      instData   = rand_inst();
      issueReady = $urandom_range(0, 3) != 0;
      wbValid    = $urandom_range(0, 2) == 0;
      wbAddress  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'(8 + $urandom_range(0, 5));
      step();
    end
    reset = 1'b0; instValid = 1'b0; wbValid = 1'b0; issueReady = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
